reg_select_sequencer: RTL

Parametrised successor to the datapath register select/encode logic. It decodes IR register fields (Ra/Rb/Rc) into one-hot register-file in/out enables and sign-extends the C immediate, with both outputs registered. It adds a multi-register sequencer for load/store-multiple: it walks a register bitmask one register per handshake. It sits between the control unit and the general-purpose register file.

---
 rtl/reg_select_sequencer.sv | 115 +++++++++++
 1 files changed

// File: rtl/reg_select_sequencer.sv
// reg_select_sequencer: IR register-field decode to one-hot enables plus a load/store-multiple sequencer.
// Define REG_SEL_SCAN_DOWN_EN to add the scan_down port (descending register order).
module reg_select_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = $clog2(NUM_REGS),
  parameter int IR_W     = 32,
  parameter int RA_LSB   = 23,
  parameter int RB_LSB   = 19,
  parameter int RC_LSB   = 15,
  parameter int IMM_W    = 18
) (
  input  logic                clock,
  input  logic                clear_n,
`ifdef REG_SEL_SCAN_DOWN_EN
  input  logic                scan_down,
`endif
  input  logic                Gra,
  input  logic                Grb,
  input  logic                Grc,
  input  logic                Rin,
  input  logic                Rout,
  input  logic                BAout,
  input  logic [IR_W-1:0]     ir_in,
  input  logic                ir_load,
  input  logic                multi_start,
  input  logic                multi_dir,
  input  logic [NUM_REGS-1:0] multi_mask,
  input  logic                multi_ready,
  output logic [NUM_REGS-1:0] registers_in,
  output logic [NUM_REGS-1:0] registers_out,
  output logic                r0_zero,
  output logic [IR_W-1:0]     c_sign_ext,
  output logic                multi_busy,
  output logic                multi_valid,
  output logic [SEL_W-1:0]    multi_idx,
  output logic                multi_done
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t              r_state;
  logic [IR_W-1:0]     r_ir;
  logic [IR_W-1:0]     r_cext;
  logic [NUM_REGS-1:0] r_rem;
  logic [NUM_REGS-1:0] r_in;
  logic [NUM_REGS-1:0] r_out;
  logic                r_r0z;
  logic                r_dir;
  logic                r_down;
  logic [SEL_W-1:0]    w_sel;
  logic [SEL_W-1:0]    w_idx;
  logic [NUM_REGS-1:0] w_sel_oh;
  logic [NUM_REGS-1:0] w_idx_oh;
  logic                w_valid;
  logic                w_idle;
  logic                w_scan_down;
  logic                w_unused;
`ifdef REG_SEL_SCAN_DOWN_EN
  assign w_scan_down = scan_down;
`else
  assign w_scan_down = 1'b0;
`endif
  assign w_unused = &{1'b0, r_ir};
  assign w_sel    = (Gra ? r_ir[RA_LSB +: SEL_W] : '0) |
                    (Grb ? r_ir[RB_LSB +: SEL_W] : '0) |
                    (Grc ? r_ir[RC_LSB +: SEL_W] : '0);
  assign w_sel_oh = NUM_REGS'(1) << w_sel;
  assign w_idx_oh = NUM_REGS'(1) << w_idx;
  assign w_idle   = (r_state == IDLE);
  assign w_valid  = (r_state == SCAN) && (|r_rem);
  // Later loop iterations win: ascending keeps the lowest set bit, descending the highest.
  always_comb begin
    w_idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--)
      if (!r_down && r_rem[i]) w_idx = SEL_W'(i);
    for (int i = 0; i < NUM_REGS; i++)
      if (r_down && r_rem[i]) w_idx = SEL_W'(i);
  end
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= IDLE;
      r_ir    <= '0;
      r_cext  <= '0;
      r_rem   <= '0;
      r_in    <= '0;
      r_out   <= '0;
      r_r0z   <= 1'b0;
      r_dir   <= 1'b0;
      r_down  <= 1'b0;
    end else begin
      if (ir_load) r_ir <= ir_in;
      r_cext <= {{(IR_W-IMM_W){r_ir[IMM_W-1]}}, r_ir[IMM_W-1:0]};
      r_in   <= (w_idle && Rin) ? w_sel_oh : '0;
      r_out  <= (w_idle && (Rout || BAout) && !(BAout && w_sel == '0)) ? w_sel_oh : '0;
      r_r0z  <= w_idle && BAout && (w_sel == '0);
      case (r_state)
        IDLE: if (multi_start) begin
          r_rem   <= multi_mask;
          r_dir   <= multi_dir;
          r_down  <= w_scan_down;
          r_state <= SCAN;
        end
        SCAN: if (r_rem == '0) r_state <= DONE;
              else if (multi_ready) r_rem <= r_rem & ~w_idx_oh;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign registers_in  = w_idle ? r_in  : ((w_valid &&  r_dir) ? w_idx_oh : '0);
  assign registers_out = w_idle ? r_out : ((w_valid && !r_dir) ? w_idx_oh : '0);
  assign r0_zero       = w_idle && r_r0z;
  assign c_sign_ext    = r_cext;
  assign multi_busy    = !w_idle;
  assign multi_valid   = w_valid;
  assign multi_idx     = w_idx;
  assign multi_done    = (r_state == DONE);
endmodule
